// File: rtl/pma_pkg.sv
// Shared types for the runtime-programmable PMA region checker:
// attribute and table-entry layouts, config FSM states and table limits.
package pma_pkg;

  localparam int PmaMaxRegions   = 64;
  localparam int PmaMaxAddrWidth = 64;

  typedef struct packed {
    logic cache;
    logic exec;
    logic nonidem;
  } pma_attr_t;

  typedef struct packed {
    logic                       en;
    pma_attr_t                  attr;
    logic [PmaMaxAddrWidth-1:0] base;
    logic [PmaMaxAddrWidth-1:0] len;
  } pma_entry_t;

  typedef enum logic [1:0] {
    CfgIdle   = 2'd0,
    CfgCommit = 2'd1,
    CfgLocked = 2'd2
  } pma_cfg_state_e;

endpackage

// File: rtl/pma_range_match.sv
// Combinational test of one address against one region [base, base+len).
// The upper bound is formed one bit wider than the address, so a region
// ending exactly at the top of the address space cannot wrap to zero.
module pma_range_match #(
  parameter int AddrWidth = 64
) (
  input  logic                 en,
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] len,
  input  logic [AddrWidth-1:0] addr,
  output logic                 match
);

  logic [AddrWidth:0] limit;

  // Bound compare; a zero-length region never matches.
  always_comb begin
    limit = {1'b0, base} + {1'b0, len};
    match = en && (len != '0) && (addr >= base) && ({1'b0, addr} < limit);
  end

endmodule

// File: rtl/pma_region_checker.sv
// Runtime-programmable PMA checker: register-backed region table with a
// write/lock config FSM and NrPorts independent one-cycle lookup channels.
// Optional feature macro: PMA_REGION_CHECKER_MULTIHIT_EN (registered
// multi-match flag per port; tied to 0 when undefined).
module pma_region_checker
  import pma_pkg::*;
#(
  parameter  int NrRegions = 16,
  parameter  int NrPorts   = 2,
  parameter  int AddrWidth = 64,
  localparam int IdxW      = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [IdxW-1:0]              cfg_idx_i,
  input  logic [AddrWidth-1:0]         cfg_base_i,
  input  logic [AddrWidth-1:0]         cfg_len_i,
  input  logic [2:0]                   cfg_attr_i,
  input  logic                         cfg_en_i,
  input  logic                         cfg_lock_i,
  output logic                         cfg_done_o,
  output logic                         cfg_err_o,
  output logic                         locked_o,
  input  logic [NrPorts-1:0]           req_valid_i,
  input  logic [NrPorts*AddrWidth-1:0] req_addr_i,
  output logic [NrPorts-1:0]           rsp_valid_o,
  output logic [NrPorts-1:0]           rsp_hit_o,
  output logic [NrPorts*IdxW-1:0]      rsp_idx_o,
  output logic [NrPorts*3-1:0]         rsp_attr_o,
  output logic [NrPorts-1:0]           rsp_multihit_o
);

  localparam logic [IdxW:0] NrRegionsW = (IdxW+1)'(NrRegions);

  pma_cfg_state_e stateQ, stateD;
  pma_entry_t     regionTable [NrRegions];
  pma_entry_t     holdEntry;
  logic [IdxW-1:0] holdIdx;
  logic           holdLock, holdBad;
  logic           cfgDoneQ, cfgDoneD, cfgErrQ, cfgErrD;
  logic           capture, tableWe, idxBad;

  // Config FSM next state and control; NOTE: every output gets a default
  // first, so no path through the case can leave a latch behind.
  always_comb begin
    stateD      = stateQ;
    cfg_ready_o = 1'b0;
    capture     = 1'b0;
    tableWe     = 1'b0;
    cfgDoneD    = 1'b0;
    cfgErrD     = 1'b0;
    idxBad      = ({1'b0, cfg_idx_i} >= NrRegionsW);
    unique case (stateQ)
      CfgIdle: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          capture  = 1'b1;
          stateD   = CfgCommit;
          cfgErrD  = idxBad;
          cfgDoneD = !idxBad;
        end
      end
      CfgCommit: begin
        tableWe = !holdBad;
        stateD  = (holdLock && !holdBad) ? CfgLocked : CfgIdle;
      end
      CfgLocked: begin
        cfg_ready_o = 1'b1;
        cfgErrD     = cfg_valid_i;
      end
      default: stateD = CfgIdle;
    endcase
  end

  // FSM state and registered done/err pulses; NOTE: state uses non-blocking
  // assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stateQ   <= CfgIdle;
      cfgDoneQ <= 1'b0;
      cfgErrQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cfgDoneQ <= cfgDoneD;
      cfgErrQ  <= cfgErrD;
    end
  end

  // Holding registers for the accepted write; only read in COMMIT.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      holdIdx   <= cfg_idx_i;
      holdLock  <= cfg_lock_i;
      holdBad   <= idxBad;
      holdEntry <= '{en:   cfg_en_i,
                     attr: pma_attr_t'(cfg_attr_i),
                     base: PmaMaxAddrWidth'(cfg_base_i),
                     len:  PmaMaxAddrWidth'(cfg_len_i)};
    end
  end

  // Region table; NOTE: this array is reset deliberately, because reset must
  // disable every entry and a reset during COMMIT has to discard the write.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < NrRegions; r++) begin
      if (!rst_ni) begin
        regionTable[r] <= '0;
      end else if (tableWe && (holdIdx == IdxW'(r))) begin
        regionTable[r] <= holdEntry;
      end
    end
  end

  assign cfg_done_o = cfgDoneQ;
  assign cfg_err_o  = cfgErrQ;
  assign locked_o   = (stateQ == CfgLocked);

  logic [NrPorts*NrRegions-1:0] matchFlat;

  for (genvar gp = 0; gp < NrPorts; gp++) begin : gPort
    for (genvar gr = 0; gr < NrRegions; gr++) begin : gRegion
      pma_range_match #(.AddrWidth(AddrWidth)) uMatch (
        .en    (regionTable[gr].en),
        .base  (regionTable[gr].base[AddrWidth-1:0]),
        .len   (regionTable[gr].len[AddrWidth-1:0]),
        .addr  (req_addr_i[gp*AddrWidth +: AddrWidth]),
        .match (matchFlat[gp*NrRegions + gr])
      );
    end
  end

  logic            anyExec;
  logic            lookHit  [NrPorts];
  logic [IdxW-1:0] lookIdx  [NrPorts];
  pma_attr_t       lookAttr [NrPorts];

  // Lowest-index priority encode per port, plus the global exec default.
  always_comb begin
    anyExec = 1'b0;
    for (int r = 0; r < NrRegions; r++) begin
      anyExec = anyExec | (regionTable[r].en & regionTable[r].attr.exec);
    end
    for (int p = 0; p < NrPorts; p++) begin
      lookHit[p]  = 1'b0;
      lookIdx[p]  = '0;
      lookAttr[p] = '0;
      for (int r = NrRegions - 1; r >= 0; r--) begin
        if (matchFlat[p*NrRegions + r]) begin
          lookHit[p]  = 1'b1;
          lookIdx[p]  = IdxW'(r);
          lookAttr[p] = regionTable[r].attr;
        end
      end
      if (!anyExec) lookAttr[p].exec = 1'b1;
    end
  end

  logic            rspValidQ [NrPorts];
  logic            rspHitQ   [NrPorts];
  logic [IdxW-1:0] rspIdxQ   [NrPorts];
  pma_attr_t       rspAttrQ  [NrPorts];

  // Response registers; payload holds its value while the port is idle.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrPorts; p++) begin
      if (!rst_ni) begin
        rspValidQ[p] <= 1'b0;
        rspHitQ[p]   <= 1'b0;
        rspIdxQ[p]   <= '0;
        rspAttrQ[p]  <= '0;
      end else begin
        rspValidQ[p] <= req_valid_i[p];
        if (req_valid_i[p]) begin
          rspHitQ[p]  <= lookHit[p];
          rspIdxQ[p]  <= lookIdx[p];
          rspAttrQ[p] <= lookAttr[p];
        end
      end
    end
  end

  for (genvar gp = 0; gp < NrPorts; gp++) begin : gOut
    assign rsp_valid_o[gp]               = rspValidQ[gp];
    assign rsp_hit_o[gp]                 = rspHitQ[gp];
    assign rsp_idx_o[gp*IdxW +: IdxW]    = rspIdxQ[gp];
    assign rsp_attr_o[gp*3 +: 3]         = rspAttrQ[gp];
  end

`ifdef PMA_REGION_CHECKER_MULTIHIT_EN
  logic [NrPorts-1:0] lookMulti, rspMultiQ;

  // More than one enabled region covers the address.
  always_comb begin
    lookMulti = '0;
    for (int p = 0; p < NrPorts; p++) begin
      lookMulti[p] = ($countones(matchFlat[p*NrRegions +: NrRegions]) > 1);
    end
  end

  // Multi-hit flag registered with the same hold rule as the other fields.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrPorts; p++) begin
      if (!rst_ni) begin
        rspMultiQ[p] <= 1'b0;
      end else if (req_valid_i[p]) begin
        rspMultiQ[p] <= lookMulti[p];
      end
    end
  end

  assign rsp_multihit_o = rspMultiQ;
`else
  assign rsp_multihit_o = '0;
`endif

endmodule

// File: doc/pma_region_checker.md
# pma_region_checker

Runtime-programmable physical memory attribute (PMA) checker. It replaces the compile-time region rule tables with a register-backed region table that software can write and then lock. Each of several lookup ports gets a registered answer with three attributes (non-idempotent, executable, cacheable) plus the matching region index. It sits beside the MMU/PMP path and serves the fetch, load and store units in parallel.

## Interface
- NrRegions, 16, number of table entries (1..64)
- NrPorts, 2, number of independent lookup channels (1..4)
- AddrWidth, 64, physical address width
- IdxW, $clog2(NrRegions) (min 1), region index width (derived, not overridable)
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- cfg_valid_i  in  1  table write request
- cfg_ready_o  out  1  write request accepted this cycle
- cfg_idx_i  in  IdxW  entry to write
- cfg_base_i  in  AddrWidth  region base
- cfg_len_i  in  AddrWidth  region length in bytes
- cfg_attr_i  in  3  {cache, exec, nonidem}
- cfg_en_i  in  1  entry enable
- cfg_lock_i  in  1  lock request, sampled with cfg_valid_i
- cfg_done_o  out  1  one-cycle pulse: write committed
- cfg_err_o  out  1  one-cycle pulse: write rejected
- locked_o  out  1  table locked
- req_valid_i  in  NrPorts  lookup valid per port
- req_addr_i  in  NrPorts×AddrWidth  lookup address
- rsp_valid_o  out  NrPorts  response valid
- rsp_hit_o  out  NrPorts  some enabled region matched
- rsp_idx_o  out  NrPorts×IdxW  lowest matching index (0 if no hit)
- rsp_attr_o  out  NrPorts×3  resolved attributes
- rsp_multihit_o  out  NrPorts  more than one region matched (see Configuration)

## Operation
- Entry match: en && len≠0 && addr ≥ base && {1'b0,addr} < {1'b0,base}+len. The sum is computed in AddrWidth+1 bits, so no wrap-around. len=0 never matches.
- Priority: the lowest matching index wins. rsp_attr_o takes that entry's attributes, with one exception for exec.
- exec exception: if no enabled entry has exec=1, exec is reported as 1 for every address, hit or miss.
- Miss, when at least one enabled entry has exec=1: attr = 3'b000, hit = 0.
- Config FSM has three states: IDLE, COMMIT, LOCKED.
  - IDLE: cfg_ready_o = 1. On cfg_valid_i, capture the request into holding registers and go to COMMIT.
  - If cfg_idx_i ≥ NrRegions: no entry is written; pulse cfg_err_o in COMMIT; return to IDLE (lock is ignored).
  - COMMIT: cfg_ready_o = 0. Write the entry and pulse cfg_done_o. Go to LOCKED if the captured lock = 1, else go to IDLE.
  - LOCKED: cfg_ready_o = 1. Every accepted request pulses cfg_err_o in the next cycle and leaves the table unchanged. The state is left only by reset.
- Lookups never stall and have no ready signal. Each port is independent.

## Timing
- Lookup latency is 1 cycle: rsp_* is registered from the req in cycle N and appears in N+1. rsp_valid_o = req_valid_i delayed by one cycle.
- rsp_* fields other than valid are held at their previous value when the corresponding req_valid_i = 0.
- A table write reaches the table at the end of the COMMIT cycle.
  - Lookups issued in the COMMIT cycle see the old entry.
  - Lookups issued from COMMIT+1 onward see the new entry.
- Write throughput: one write per 2 cycles.
- cfg_done_o and cfg_err_o are both registered and never high together.
- Reset values:
  - All entries: en = 0, base = len = attr = 0.
  - FSM in IDLE, locked_o = 0, cfg_ready_o = 1.
  - cfg_done_o = cfg_err_o = 0.
  - All rsp_* outputs = 0.
- Reset mid-COMMIT: the write is discarded.
- Reset while LOCKED: the table unlocks.

## Configuration
- Macro: PMA_REGION_CHECKER_MULTIHIT_EN.
- Defined: rsp_multihit_o = registered (popcount(matches) > 1), with the same timing as the other rsp_* fields.
- Undefined: rsp_multihit_o is tied to 0 and no popcount logic is built.

## Structure
- Shared package pma_pkg holds:
  - pma_attr_t: packed {cache, exec, nonidem}.
  - pma_entry_t: packed {en, attr, base, len}.
  - The FSM state enum.
  - PmaMaxRegions = 64.
- Sub-module pma_range_match: purely combinational, one entry against one address, producing a match bit. It is instantiated NrRegions×NrPorts times.
- Top level holds the table registers, the config FSM, the priority encoder and the response registers.

## Test plan
- Reset and miss check:
  - Stimulus: apply reset, then look up 0x8000_0000 on port 0.
  - Response: rsp_valid=1 one cycle later, hit=0, attr=3'b010 (exec defaults to 1 because no exec region is set).
- Write and boundary check:
  - Stimulus: write idx 3 with base 0x8000_0000, len 0x1000, attr 3'b110, en=1.
  - Response: cfg_done_o in COMMIT.
  - Then 0x8000_0FFF gives hit=1, idx=3, attr=3'b110; 0x8000_1000 gives hit=0, attr=3'b000.
- Priority and multihit:
  - Stimulus: overlapping idx 1 (attr 3'b001) and idx 5 (attr 3'b100); look up an address inside both.
  - Response: idx=1, attr=3'b001, multihit=1 with the macro defined, 0 without.
- Top-of-space region:
  - Stimulus: base 0xFFFF_FFFF_FFFF_F000, len 0x1000; look up 0xFFFF_FFFF_FFFF_FFFF.
  - Response: hit=1, showing no overflow in the bound compare.
- Write/lookup collision:
  - Stimulus: a lookup issued in the COMMIT cycle.
  - Response: it returns the old entry; the same lookup one cycle later returns the new entry.
- Lock and bad index:
  - Stimulus: write with cfg_lock_i=1, then a further write; separately, in IDLE, a write to idx=NrRegions.
  - Response: locked_o=1; the further write produces a cfg_err_o pulse and the table is unchanged. The out-of-range write produces cfg_err_o with no entry changed.
